// File: rtl/world_pkg.sv
// Shared cell codes, orientation codes and the turn-left rule for the grid world.
// No logic of its own; consumed by the engine and its neighbour helper.
// Constants only, no flow control.
package world_pkg;

   localparam logic [2:0] CELL_FREE  = 3'd0;
   localparam logic [2:0] CELL_WALL  = 3'd1;
   localparam logic [2:0] CELL_TRASH = 3'd2;
   localparam logic [2:0] CELL_MARK  = 3'd7;

   localparam logic [1:0] OR_N = 2'd0;
   localparam logic [1:0] OR_S = 2'd1;
   localparam logic [1:0] OR_E = 2'd2;
   localparam logic [1:0] OR_W = 2'd3;

   // Robot turns counter-clockwise: N -> W -> S -> E -> N
   function automatic logic [1:0] turn_left(input logic [1:0] o);
      case (o)
         OR_N:    return OR_W;
         OR_W:    return OR_S;
         OR_S:    return OR_E;
         default: return OR_N;
      endcase
   endfunction

endpackage

// File: rtl/grid_neighbor.sv
// Ahead/left neighbour coordinates, in-bounds flags and linear addresses for a pose.
// Purely combinational, zero latency.
// No flow control; addresses are forced to 0 when the neighbour is out of bounds.
module grid_neighbor
   import world_pkg::*;
#(
   parameter int ROWS = 10,
   parameter int COLS = 20,
   parameter int RW   = $clog2(ROWS),
   parameter int CW   = $clog2(COLS),
   parameter int AW   = $clog2(ROWS * COLS)
) (
   input  logic [RW-1:0] row,
   input  logic [CW-1:0] col,
   input  logic [1:0]    orient,
   output logic [RW-1:0] ahead_row,
   output logic [CW-1:0] ahead_col,
   output logic          ahead_valid,
   output logic [AW-1:0] ahead_addr,
   output logic          left_valid,
   output logic [AW-1:0] left_addr,
   output logic [AW-1:0] cur_addr
);

   int r, c, ar, ac, lr, lc;

   // Step one cell in the facing direction and one cell to the robot's left
   always_comb begin
      r  = int'(row);
      c  = int'(col);
      ar = r;
      ac = c;
      lr = r;
      lc = c;
      case (orient)
         OR_N: begin
            ar = r - 1;
            lc = c - 1;
         end
         OR_S: begin
            ar = r + 1;
            lc = c + 1;
         end
         OR_E: begin
            ac = c + 1;
            lr = r - 1;
         end
         default: begin
            ac = c - 1;
            lr = r + 1;
         end
      endcase

      ahead_valid = (ar >= 0) && (ar < ROWS) && (ac >= 0) && (ac < COLS);
      left_valid  = (lr >= 0) && (lr < ROWS) && (lc >= 0) && (lc < COLS);

      ahead_row  = ahead_valid ? RW'(ar) : row;
      ahead_col  = ahead_valid ? CW'(ac) : col;
      ahead_addr = ahead_valid ? AW'(ar * COLS + ac) : '0;
      left_addr  = left_valid  ? AW'(lr * COLS + lc) : '0;
      cur_addr   = AW'(r * COLS + c);
   end

endmodule

// File: rtl/grid_world_engine.sv
// Grid world: map storage, robot pose, two-phase robot clock, sensors and command execution.
// Sensors update on the SENSE edge, commands apply on the ACT edge; read port has 1-cycle latency.
// No backpressure: commands are sampled once per ACT edge, map writes only accepted in LOAD.
module grid_world_engine
   import world_pkg::*;
#(
   parameter int ROWS         = 10,
   parameter int COLS         = 20,
   parameter int TICK_DIV     = 1,
   parameter int REMOVE_TICKS = 3,
   parameter int CNT_W        = 16
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            start,
   input  logic [$clog2(ROWS)-1:0]         start_row,
   input  logic [$clog2(COLS)-1:0]         start_col,
   input  logic [1:0]                      start_orient,
   input  logic                            map_we,
   input  logic [$clog2(ROWS*COLS)-1:0]    map_addr,
   input  logic [2:0]                      map_wdata,
   input  logic                            front,
   input  logic                            turn,
   input  logic                            remove,
   output logic                            robot_clock,
   output logic                            head,
   output logic                            left,
   output logic                            under,
   output logic                            barrier,
   output logic [$clog2(ROWS)-1:0]         robot_row,
   output logic [$clog2(COLS)-1:0]         robot_col,
   output logic [1:0]                      robot_orient,
   output logic                            running,
   output logic                            collision,
   output logic [CNT_W-1:0]                step_count,
   output logic [CNT_W-1:0]                trash_count,
   input  logic [$clog2(ROWS)-1:0]         rd_row,
   input  logic [$clog2(COLS)-1:0]         rd_col,
   output logic [2:0]                      rd_cell,
   output logic                            rd_robot
);

   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int CELLS = ROWS * COLS;
   localparam int AW    = $clog2(CELLS);
   localparam int DW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MW    = $clog2(REMOVE_TICKS + 1);

   typedef enum logic {ST_LOAD, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [RW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [1:0]        orient_q, orient_d;
   logic [DW-1:0]     div_q, div_d;
   logic              rclk_q, rclk_d;
   logic              head_q, head_d;
   logic              left_q, left_d;
   logic              under_q, under_d;
   logic              barrier_q, barrier_d;
   logic              coll_q, coll_d;
   logic [CNT_W-1:0]  step_q, step_d;
   logic [CNT_W-1:0]  trash_q, trash_d;
   logic [MW-1:0]     rm_q, rm_d;
   logic [2:0]        rd_cell_q, rd_cell_d;
   logic              rd_robot_q, rd_robot_d;

   logic [2:0]        map_q [CELLS];
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [2:0]        wr_dat;

   logic [RW-1:0]     ahead_row;
   logic [CW-1:0]     ahead_col;
   logic              ahead_valid, left_valid;
   logic [AW-1:0]     ahead_addr, left_addr, cur_addr;
   logic [2:0]        ahead_cell, left_cell, cur_cell;
   logic              ahead_blocked, ahead_trash, left_blocked;
   logic              rd_in_range;
   logic [AW-1:0]     rd_addr;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   grid_neighbor #(
      .ROWS (ROWS),
      .COLS (COLS),
      .RW   (RW),
      .CW   (CW),
      .AW   (AW)
   ) u_nbr (
      .row         (row_q),
      .col         (col_q),
      .orient      (orient_q),
      .ahead_row   (ahead_row),
      .ahead_col   (ahead_col),
      .ahead_valid (ahead_valid),
      .ahead_addr  (ahead_addr),
      .left_valid  (left_valid),
      .left_addr   (left_addr),
      .cur_addr    (cur_addr)
   );

   // Classify the cells around the robot; out-of-bounds counts as a wall
   always_comb begin
      ahead_cell    = map_q[ahead_addr];
      left_cell     = map_q[left_addr];
      cur_cell      = map_q[cur_addr];
      ahead_blocked = !ahead_valid || (ahead_cell == CELL_WALL);
      ahead_trash   = ahead_valid && (ahead_cell == CELL_TRASH);
      left_blocked  = !left_valid || (left_cell == CELL_WALL);
   end

   // Next-state: load/start, robot clock divider, sense and act phases, read port
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      orient_d   = orient_q;
      div_d      = div_q;
      rclk_d     = rclk_q;
      head_d     = head_q;
      left_d     = left_q;
      under_d    = under_q;
      barrier_d  = barrier_q;
      coll_d     = coll_q;
      step_d     = step_q;
      trash_d    = trash_q;
      rm_d       = rm_q;
      wr_en      = 1'b0;
      wr_addr    = map_addr;
      wr_dat     = map_wdata;

      case (state_q)
         ST_LOAD: begin
            if (map_we && (int'(map_addr) < CELLS)) begin
               wr_en = 1'b1;
            end
            if (start) begin
               state_d  = ST_RUN;
               row_d    = start_row;
               col_d    = start_col;
               orient_d = start_orient;
               div_d    = '0;
               rclk_d   = 1'b0;
               rm_d     = '0;
            end
         end
         ST_RUN: begin
            if (div_q == DW'(TICK_DIV - 1)) begin
               div_d  = '0;
               rclk_d = ~rclk_q;
               if (rclk_q) begin
                  // SENSE edge: robot clock falls, sensors settle before it rises again
                  head_d    = ahead_blocked;
                  left_d    = left_blocked;
                  under_d   = (cur_cell == CELL_MARK);
                  barrier_d = ahead_trash;
               end else if (remove) begin
                  // ACT edge, remove wins: front/turn ignored while digging
                  if (rm_q == MW'(REMOVE_TICKS - 1)) begin
                     rm_d = '0;
                     if (ahead_trash) begin
                        wr_en   = 1'b1;
                        wr_addr = ahead_addr;
                        wr_dat  = CELL_FREE;
                        trash_d = sat_inc(trash_q);
                     end
                  end else begin
                     rm_d = rm_q + MW'(1);
                  end
               end else begin
                  rm_d = '0;
                  if (front) begin
                     if (ahead_blocked || ahead_trash) begin
                        coll_d = 1'b1;
                     end else begin
                        row_d  = ahead_row;
                        col_d  = ahead_col;
                        step_d = sat_inc(step_q);
                     end
                  end else if (turn) begin
                     orient_d = turn_left(orient_q);
                     step_d   = sat_inc(step_q);
                  end
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         default: state_d = ST_LOAD;
      endcase

      rd_in_range = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
      rd_addr     = rd_in_range ? AW'(int'(rd_row) * COLS + int'(rd_col)) : '0;
      rd_cell_d   = rd_in_range ? map_q[rd_addr] : CELL_WALL;
      rd_robot_d  = rd_in_range && (rd_row == row_q) && (rd_col == col_q);
   end

   // Control, pose, sensor, statistics and read-port registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_LOAD;
         row_q      <= '0;
         col_q      <= '0;
         orient_q   <= OR_N;
         div_q      <= '0;
         rclk_q     <= 1'b0;
         head_q     <= 1'b0;
         left_q     <= 1'b0;
         under_q    <= 1'b0;
         barrier_q  <= 1'b0;
         coll_q     <= 1'b0;
         step_q     <= '0;
         trash_q    <= '0;
         rm_q       <= '0;
         rd_cell_q  <= '0;
         rd_robot_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         orient_q   <= orient_d;
         div_q      <= div_d;
         rclk_q     <= rclk_d;
         head_q     <= head_d;
         left_q     <= left_d;
         under_q    <= under_d;
         barrier_q  <= barrier_d;
         coll_q     <= coll_d;
         step_q     <= step_d;
         trash_q    <= trash_d;
         rm_q       <= rm_d;
         rd_cell_q  <= rd_cell_d;
         rd_robot_q <= rd_robot_d;
      end
   end

   // Map storage: cleared wholesale by reset, one write per cycle otherwise
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < CELLS; i++) begin
            map_q[i] <= CELL_FREE;
         end
      end else if (wr_en) begin
         map_q[wr_addr] <= wr_dat;
      end
   end

   assign robot_clock  = rclk_q;
   assign head         = head_q;
   assign left         = left_q;
   assign under        = under_q;
   assign barrier      = barrier_q;
   assign robot_row    = row_q;
   assign robot_col    = col_q;
   assign robot_orient = orient_q;
   assign running      = (state_q == ST_RUN);
   assign collision    = coll_q;
   assign step_count   = step_q;
   assign trash_count  = trash_q;
   assign rd_cell      = rd_cell_q;
   assign rd_robot     = rd_robot_q;

endmodule

// File: tb/tb_grid_world_engine.sv
// Randomised and directed bench for grid_world_engine against a behavioural world model.
// Model advances once per clock from the inputs seen at each rising edge.
// Robot clock phase is predicted by the model from its own cycle count.
module tb_grid_world_engine;

   localparam int ROWS  = 4;
   localparam int COLS  = 5;
   localparam int TD    = 1;
   localparam int RT    = 3;
   localparam int CNTW  = 4;
   localparam int CELLS = ROWS * COLS;
   localparam int SAT   = (1 << CNTW) - 1;

   logic             clock = 1'b0;
   logic             reset, start, map_we, front, turn, remove;
   logic [1:0]       start_row, rd_row;
   logic [2:0]       start_col, rd_col;
   logic [1:0]       start_orient;
   logic [4:0]       map_addr;
   logic [2:0]       map_wdata;
   logic             robot_clock, head, left, under, barrier, running, collision, rd_robot;
   logic [1:0]       robot_row, robot_orient;
   logic [2:0]       robot_col, rd_cell;
   logic [CNTW-1:0]  step_count, trash_count;

   grid_world_engine #(
      .ROWS(ROWS), .COLS(COLS), .TICK_DIV(TD), .REMOVE_TICKS(RT), .CNT_W(CNTW)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .start_row(start_row),
      .start_col(start_col), .start_orient(start_orient), .map_we(map_we),
      .map_addr(map_addr), .map_wdata(map_wdata), .front(front), .turn(turn),
      .remove(remove), .robot_clock(robot_clock), .head(head), .left(left),
      .under(under), .barrier(barrier), .robot_row(robot_row), .robot_col(robot_col),
      .robot_orient(robot_orient), .running(running), .collision(collision),
      .step_count(step_count), .trash_count(trash_count), .rd_row(rd_row),
      .rd_col(rd_col), .rd_cell(rd_cell), .rd_robot(rd_robot)
   );

   always #5 clock = ~clock;

   // Reference world
   int m_map [CELLS];
   int m_r, m_c, m_o, m_n, m_rc, m_rmc;
   int m_head, m_left, m_under, m_barrier, m_coll, m_step, m_trash;
   bit m_run;
   int e_rd_cell, e_rd_robot;
   int n_tests, n_fail;

   // Facing direction offsets for N,S,E,W and the orientation to the robot's left
   int DR [4] = '{-1, 1, 0, 0};
   int DC [4] = '{0, 0, 1, -1};
   int LO [4] = '{3, 2, 0, 1};

   function automatic int cell_at(int r, int c);
      if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return -1;
      return m_map[r * COLS + c];
   endfunction

   function automatic void model_reset();
      foreach (m_map[i]) m_map[i] = 0;
      m_r = 0; m_c = 0; m_o = 0; m_n = 0; m_rc = 0; m_rmc = 0; m_run = 0;
      m_head = 0; m_left = 0; m_under = 0; m_barrier = 0;
      m_coll = 0; m_step = 0; m_trash = 0;
   endfunction

   function automatic void model_sense();
      int ca, cl;
      ca = cell_at(m_r + DR[m_o], m_c + DC[m_o]);
      cl = cell_at(m_r + DR[LO[m_o]], m_c + DC[LO[m_o]]);
      m_head    = (ca < 0 || ca == 1) ? 1 : 0;
      m_left    = (cl < 0 || cl == 1) ? 1 : 0;
      m_under   = (m_map[m_r * COLS + m_c] == 7) ? 1 : 0;
      m_barrier = (ca == 2) ? 1 : 0;
   endfunction

   function automatic void model_act(int f, int t, int rm);
      int ar, ac, ca;
      ar = m_r + DR[m_o];
      ac = m_c + DC[m_o];
      ca = cell_at(ar, ac);
      if (rm != 0) begin
         m_rmc++;
         if (m_rmc == RT) begin
            if (ca == 2) begin
               m_map[ar * COLS + ac] = 0;
               if (m_trash < SAT) m_trash++;
            end
            m_rmc = 0;
         end
      end else begin
         m_rmc = 0;
         if (f != 0) begin
            if (ca < 0 || ca == 1 || ca == 2) m_coll = 1;
            else begin
               m_r = ar; m_c = ac;
               if (m_step < SAT) m_step++;
            end
         end else if (t != 0) begin
            m_o = LO[m_o];
            if (m_step < SAT) m_step++;
         end
      end
   endfunction

   function automatic logic [21:0] model_vec();
      return {2'(m_r), 3'(m_c), 2'(m_o), 1'(m_head), 1'(m_left), 1'(m_under),
              1'(m_barrier), 1'(m_coll), 4'(m_step), 4'(m_trash), 1'(m_run), 1'(m_rc)};
   endfunction

   function automatic logic [21:0] dut_vec();
      return {robot_row, robot_col, robot_orient, head, left, under, barrier,
              collision, step_count, trash_count, running, robot_clock};
   endfunction

   // One clock: wait for the falling edge, then replay the rising edge on the model
   task automatic step_cycle();
      int nrc;
      @(negedge clock);
      if (reset) begin
         model_reset();
         e_rd_cell = 0; e_rd_robot = 0;
      end else begin
         if (int'(rd_row) >= ROWS || int'(rd_col) >= COLS) begin
            e_rd_cell = 1; e_rd_robot = 0;
         end else begin
            e_rd_cell  = m_map[int'(rd_row) * COLS + int'(rd_col)];
            e_rd_robot = (int'(rd_row) == m_r && int'(rd_col) == m_c) ? 1 : 0;
         end
         if (!m_run) begin
            if (map_we && int'(map_addr) < CELLS) m_map[map_addr] = int'(map_wdata);
            if (start) begin
               m_r = start_row; m_c = start_col; m_o = start_orient;
               m_run = 1; m_n = 0; m_rc = 0; m_rmc = 0;
            end
         end else begin
            m_n++;
            nrc = (m_n / TD) % 2;
            if (nrc == 1 && m_rc == 0) model_act(front, turn, remove);
            else if (nrc == 0 && m_rc == 1) model_sense();
            m_rc = nrc;
         end
      end
   endtask

   task automatic robot_cycle(input logic f, input logic t, input logic rm);
      front = f; turn = t; remove = rm;
      for (int k = 0; k < 4 * TD && m_rc == 0; k++) step_cycle();
      front = 0; turn = 0; remove = 0;
      for (int k = 0; k < 4 * TD && m_rc == 1; k++) step_cycle();
   endtask

   task automatic do_reset();
      reset = 1; step_cycle(); step_cycle(); reset = 0;
   endtask

   task automatic load_cell(input int addr, input int val);
      map_we = 1; map_addr = 5'(addr); map_wdata = 3'(val);
      step_cycle();
      map_we = 0;
   endtask

   task automatic do_start(input int r, input int c, input int o);
      start = 1; start_row = 2'(r); start_col = 3'(c); start_orient = 2'(o);
      step_cycle();
      start = 0;
   endtask

   task automatic test_reset();
      rd_row = 0; rd_col = 0;
      do_reset();
      n_tests++;
      if (dut_vec() !== 22'd0) begin
         n_fail++; $display("FAIL reset_state: got %h want 0", dut_vec());
      end
      n_tests++;
      if ({rd_cell, rd_robot} !== 4'd0) begin
         n_fail++; $display("FAIL reset_rd: got %h want 0", {rd_cell, rd_robot});
      end
   endtask

   task automatic test_north_sensors();
      do_reset();
      do_start(0, 2, 0);
      robot_cycle(0, 0, 0);
      n_tests++;
      if ({head, left, under, barrier} !== 4'b1000) begin
         n_fail++; $display("FAIL north_sensors: got %b want 1000", {head, left, under, barrier});
      end
      n_tests++;
      if (dut_vec() !== model_vec()) begin
         n_fail++; $display("FAIL north_state: got %h want %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_move_turn();
      do_reset();
      do_start(3, 0, 0);
      robot_cycle(1, 0, 0);
      robot_cycle(1, 0, 0);
      robot_cycle(0, 1, 0);
      n_tests++;
      if ({robot_row, robot_col, robot_orient, step_count, collision} !== {2'd1, 3'd0, 2'd3, 4'd3, 1'b0}) begin
         n_fail++; $display("FAIL move_turn: got %h want %h",
            {robot_row, robot_col, robot_orient, step_count, collision}, {2'd1, 3'd0, 2'd3, 4'd3, 1'b0});
      end
      n_tests++;
      if (dut_vec() !== model_vec()) begin
         n_fail++; $display("FAIL move_turn_state: got %h want %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_blocked();
      do_reset();
      load_cell(1 * COLS + 2, 1);
      do_start(2, 2, 0);
      robot_cycle(1, 0, 0);
      n_tests++;
      if ({robot_row, robot_col, robot_orient, collision, step_count, head} !== {2'd2, 3'd2, 2'd0, 1'b1, 4'd0, 1'b1}) begin
         n_fail++; $display("FAIL blocked: got %h want %h",
            {robot_row, robot_col, robot_orient, collision, step_count, head}, {2'd2, 3'd2, 2'd0, 1'b1, 4'd0, 1'b1});
      end
   endtask

   task automatic test_trash();
      int pat [6] = '{1, 1, 0, 1, 1, 1};
      do_reset();
      load_cell(1 * COLS + 2, 2);
      rd_row = 1; rd_col = 2;
      do_start(2, 2, 0);
      for (int i = 0; i < 6; i++) begin
         robot_cycle(0, 0, 1'(pat[i]));
         n_tests++;
         if (rd_cell !== ((i == 5) ? 3'd0 : 3'd2) || int'(rd_cell) != e_rd_cell) begin
            n_fail++; $display("FAIL trash_cell edge %0d: got %0d want %0d", i + 1, rd_cell, (i == 5) ? 0 : 2);
         end
      end
      n_tests++;
      if ({trash_count, barrier} !== {4'd1, 1'b0}) begin
         n_fail++; $display("FAIL trash_done: got %h want %h", {trash_count, barrier}, {4'd1, 1'b0});
      end
   endtask

   task automatic test_read_gating();
      do_reset();
      do_start(1, 3, 2);
      robot_cycle(0, 0, 0);
      map_we = 1; map_addr = 0; map_wdata = 1; rd_row = 0; rd_col = 0;
      step_cycle();
      map_we = 0;
      step_cycle();
      n_tests++;
      if (rd_cell !== 3'd0 || int'(rd_cell) != e_rd_cell) begin
         n_fail++; $display("FAIL run_write_gated: got %0d want 0", rd_cell);
      end
      start = 1; start_row = 0; start_col = 0; start_orient = 0;
      rd_row = 1; rd_col = 3;
      step_cycle();
      start = 0;
      step_cycle();
      n_tests++;
      if ({rd_robot, robot_row, robot_col, robot_orient} !== {1'b1, 2'd1, 3'd3, 2'd2}) begin
         n_fail++; $display("FAIL rd_robot_start_ignored: got %h want %h",
            {rd_robot, robot_row, robot_col, robot_orient}, {1'b1, 2'd1, 3'd3, 2'd2});
      end
      rd_col = 6;
      step_cycle();
      n_tests++;
      if ({rd_cell, rd_robot} !== {3'd1, 1'b0}) begin
         n_fail++; $display("FAIL rd_oob: got %h want %h", {rd_cell, rd_robot}, {3'd1, 1'b0});
      end
   endtask

   task automatic test_saturation();
      do_reset();
      do_start(1, 1, 0);
      for (int i = 0; i < 20; i++) robot_cycle(0, 1, 0);
      n_tests++;
      if ({step_count, robot_orient} !== {4'd15, 2'd0}) begin
         n_fail++; $display("FAIL step_saturate: got %h want %h", {step_count, robot_orient}, {4'd15, 2'd0});
      end
   endtask

   task automatic test_random();
      int codes [8] = '{0, 1, 2, 7, 3, 5, 0, 2};
      do_reset();
      for (int i = 0; i < 24; i++) load_cell($urandom_range(0, 31), codes[$urandom_range(0, 7)]);
      load_cell(CELLS - 1, 1);
      do_start($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), $urandom_range(0, 3));
      for (int i = 0; i < 80; i++) begin
         rd_row = 2'($urandom_range(0, 3));
         rd_col = 3'($urandom_range(0, 7));
         robot_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
         n_tests++;
         if (dut_vec() !== model_vec() || int'(rd_cell) != e_rd_cell || int'(rd_robot) != e_rd_robot) begin
            n_fail++; $display("FAIL random cycle %0d: got %h/%0d/%0d want %h/%0d/%0d", i,
               dut_vec(), rd_cell, rd_robot, model_vec(), e_rd_cell, e_rd_robot);
         end
      end
   endtask

   task automatic test_mid_reset();
      int nonzero;
      front = 1; reset = 1;
      step_cycle();
      reset = 0; front = 0;
      n_tests++;
      if ({robot_row, robot_col, robot_orient, robot_clock, running} !== 9'd0) begin
         n_fail++; $display("FAIL mid_reset_state: got %h want 0",
            {robot_row, robot_col, robot_orient, robot_clock, running});
      end
      nonzero = 0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            rd_row = 2'(r); rd_col = 3'(c);
            step_cycle();
            if (rd_cell !== 3'd0) nonzero++;
         end
      end
      n_tests++;
      if (nonzero != 0) begin
         n_fail++; $display("FAIL mid_reset_map: got %0d nonzero cells want 0", nonzero);
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1; start = 0; map_we = 0; front = 0; turn = 0; remove = 0;
      start_row = 0; start_col = 0; start_orient = 0;
      map_addr = 0; map_wdata = 0; rd_row = 0; rd_col = 0;
      model_reset();
      e_rd_cell = 0; e_rd_robot = 0;
      test_reset();
      test_north_sensors();
      test_move_turn();
      test_blocked();
      test_trash();
      test_read_gating();
      test_saturation();
      test_random();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/grid_world_engine.md
Name: grid_world_engine

Overview:
- Parametrised successor of the fixed 10x20 world: holds the pipe map in an internal register array and tracks the robot pose.
- Generates the two-phase robot clock, computes the head/left/under/barrier sensors, applies front/turn/remove commands with bounds and collision checks, and counts removal ticks.
- The map is loaded through a write port instead of a file. A one-cycle-latency read port serves the VGA renderer.
- Sits between the robot FSM and the VGA block.

Parameters:
- ROWS, 10, map rows (2..63).
- COLS, 20, map columns (2..63).
- TICK_DIV, 1, clock cycles per robot_clock half-period (>=1).
- REMOVE_TICKS, 3, consecutive action ticks with remove=1 needed to clear a trash cell (>=1).
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches the start pose and leaves LOAD
- start_row  in  $clog2(ROWS)  initial row, 0-based
- start_col  in  $clog2(COLS)  initial column, 0-based
- start_orient  in  2  initial orientation
- map_we  in  1  map write strobe; honoured only in LOAD
- map_addr  in  $clog2(ROWS*COLS)  address = row*COLS+col
- map_wdata  in  3  cell code
- front  in  1  robot command: step forward
- turn  in  1  robot command: turn left
- remove  in  1  robot command: remove trash ahead
- robot_clock  out  1  clock driven to the robot
- head  out  1  sensor: blocked ahead
- left  out  1  sensor: blocked to the left
- under  out  1  sensor: pipe mark under the robot
- barrier  out  1  sensor: trash ahead
- robot_row  out  $clog2(ROWS)  current row
- robot_col  out  $clog2(COLS)  current column
- robot_orient  out  2  current orientation
- running  out  1  high in RUN
- collision  out  1  sticky flag, set on a blocked front command
- step_count  out  CNT_W  moves plus turns executed
- trash_count  out  CNT_W  trash cells cleared
- rd_row  in  $clog2(ROWS)  VGA read row
- rd_col  in  $clog2(COLS)  VGA read column
- rd_cell  out  3  registered cell code at (rd_row, rd_col)
- rd_robot  out  1  registered; 1 when (rd_row, rd_col) equals the robot position

Behaviour:
- Cell codes: 0 FREE, 1 WALL, 2 TRASH, 7 MARK; other codes are treated as FREE.
- Orientation codes: N=0, S=1, E=2, W=3.
- Reset values:
  - state LOAD; every map cell FREE
  - pose row 0, col 0, orientation N
  - all sensors 0, robot_clock 0
  - counters 0, collision 0, running 0
  - rd_cell 0, rd_robot 0
  - divider 0, remove counter 0
- LOAD state:
  - map_we writes map_wdata into map[map_addr]; writes with map_addr >= ROWS*COLS are ignored.
  - start latches start_row/start_col/start_orient and moves to RUN.
  - If start and map_we occur in the same cycle, the write completes first.
- RUN state:
  - The divider counts 0..TICK_DIV-1. On terminal count, robot_clock toggles.
  - Terminal count with robot_clock=1 is the SENSE edge. Sensors are registered from the current map and pose and are stable before the next rising edge.
  - Terminal count with robot_clock=0 is the ACT edge. Commands are sampled and applied in the same cycle robot_clock rises.
  - map_we is ignored in RUN.
- Neighbour definitions (ahead / left):
  - N: (r-1, c) / (r, c-1)
  - S: (r+1, c) / (r, c+1)
  - E: (r, c+1) / (r-1, c)
  - W: (r, c-1) / (r+1, c)
- Sensors:
  - head = ahead cell out of bounds or WALL
  - left = left cell out of bounds or WALL
  - under = current cell is MARK
  - barrier = ahead cell in bounds and TRASH
- ACT priority: remove > front > turn.
- Remove:
  - Increments the remove counter. Front and turn are suppressed.
  - When the counter reaches REMOVE_TICKS: if the ahead cell is in bounds and TRASH, write FREE and increment trash_count; reset the counter to 0 in either case.
  - Any ACT edge with remove=0 clears the counter.
- Front:
  - If the ahead cell is out of bounds, WALL or TRASH: pose unchanged, collision set to 1.
  - Otherwise the robot moves to the ahead cell and step_count increments.
- Turn: orientation N->W, W->S, S->E, E->N; step_count increments.
- Statistics counters saturate at all-ones.
- Read port: rd_cell and rd_robot are valid one cycle after rd_row/rd_col are presented. Out-of-range coordinates return rd_cell=WALL, rd_robot=0.
- Reset asserted mid-operation returns every register, the map included, to its reset value within one cycle.
- start asserted in RUN is ignored.

Decomposition:
- Package world_pkg holds:
  - cell code constants CELL_FREE, CELL_WALL, CELL_TRASH, CELL_MARK
  - orientation constants OR_N, OR_S, OR_E, OR_W
  - function turn_left
- Sub-module grid_neighbor is combinational. From pose, ROWS and COLS it produces:
  - ahead and left coordinates
  - ahead_valid and left_valid (in-bounds flags)
  - linear addresses
- grid_neighbor is instantiated once and shared by sensing, acting and removal.

Test Plan:
- Sensors at the north edge: load a 4x5 map all FREE, start at (0,2,N), TICK_DIV=1 -> after the first SENSE edge head=1, left=0, under=0, barrier=0.
- Move and turn: front=1 for 2 ACT edges from (3,0,N), then turn=1 -> pose ends at (1,0,W), step_count=3, collision=0.
- Blocked move: map[1*5+2]=WALL, pose (2,2,N), front=1 -> pose stays (2,2,N), collision=1, step_count unchanged.
- Trash removal: TRASH at (1,2), pose (2,2,N), REMOVE_TICKS=3; remove=1 for 2 ACT edges, 0 for 1 edge, then 1 for 3 edges -> cell stays 2 until the 6th edge, then 0; trash_count=1; next SENSE edge gives barrier=0.
- Read port and write gating: a map_we in RUN to (0,0) with value 1 is ignored -> rd_row=0, rd_col=0 returns rd_cell=0 one cycle later; the robot cell returns rd_robot=1.
- Mid-run reset: reset asserted at an ACT edge -> next cycle pose (0,0,N), robot_clock=0, running=0, all map cells 0.
